matmul_seq_ctrl: RTL and testbench

- Downstream consumer of the operand data memories (32-bit words, 7-bit address, combinational read).
- Sequences the addresses for operand memories A and B and accumulates the dot products to compute C = A x B for N x N unsigned matrices.
- Writes each C element to the result memory through its write-enable port.
- This is the datapath/FSM core of the matrix multiplier.

---
 rtl/matmul_pkg.sv | 36 +++
 rtl/matmul_seq_ctrl_mac_unit.sv | 91 +++++++++
 rtl/matmul_seq_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_matmul_seq_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// ---------------------------------------------------------------------------
// matmul_pkg
//
// Shared definitions for the sequential matrix-multiply controller.
//
// Contents:
//    state_t    : controller state encoding {IDLE, MAC, WRITE, DONE}
//    DEF_DW     : default data word width (32)
//    DEF_AW     : default memory address width (7)
//    MEM_DEPTH  : words per operand/result memory (100, enough for N=10)
//    MAX_N      : largest matrix dimension that fits in MEM_DEPTH
//
// Optional feature macro used by the files that import this package:
//    MATMUL_SAT_EN - saturating multiply/accumulate plus a sticky 'sat' flag.
// ---------------------------------------------------------------------------
package matmul_pkg;

   localparam int DEF_DW    = 32;
   localparam int DEF_AW    = 7;
   localparam int MEM_DEPTH = 100;
   localparam int MIN_N     = 2;
   localparam int MAX_N     = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAC   = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Row-major flat address of element [row][col] in an n x n matrix.
   function automatic int flat_index(input int row, input int col, input int n);
      return row * n + col;
   endfunction

endpackage

// File: rtl/matmul_seq_ctrl_mac_unit.sv
// ---------------------------------------------------------------------------
// mac_unit
//
// Accumulator register with a multiply-add in front of it. Each enabled cycle
// adds a*b to the running sum. By default the arithmetic wraps modulo 2^DW;
// when MATMUL_SAT_EN is defined both the product and the sum clamp to
// 2^DW-1 and a sticky 'sat' flag records that clamping happened.
//
// Ports:
//    clk      in   system clock, rising edge
//    rst      in   asynchronous active-low reset
//    clr      in   synchronous clear of the accumulator (wins over en)
//    en       in   accumulate a*b this cycle
//    a, b     in   DW-bit unsigned operands
//    acc      out  DW-bit accumulator value
//    sat_clr  in   (MATMUL_SAT_EN only) clear the sticky saturation flag
//    sat      out  (MATMUL_SAT_EN only) sticky saturation flag
// ---------------------------------------------------------------------------
module mac_unit
   import matmul_pkg::*;
#(
   parameter int DW = DEF_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
`ifdef MATMUL_SAT_EN
   input  logic          sat_clr,
   output logic          sat,
`endif
   output logic [DW-1:0] acc
);

   logic [DW-1:0] next_acc;

`ifdef MATMUL_SAT_EN
   logic [2*DW-1:0] prod_full;
   logic [DW-1:0]   prod;
   logic [DW:0]     sum_full;
   logic            prod_ovf;
   logic            sum_ovf;
   logic            sat_event;

   // The full-width product exposes overflow in its upper half; the sum keeps
   // one carry bit. Either overflow clamps to all-ones.
   always_comb begin
      prod_full = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
      prod_ovf  = |prod_full[2*DW-1:DW];
      prod      = prod_ovf ? {DW{1'b1}} : prod_full[DW-1:0];
      sum_full  = {1'b0, acc} + {1'b0, prod};
      sum_ovf   = sum_full[DW];
      next_acc  = sum_ovf ? {DW{1'b1}} : sum_full[DW-1:0];
      sat_event = en && (prod_ovf || sum_ovf);
   end

   // Sticky flag: set by any clamp, cleared only by an accepted start.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sat <= 1'b0;
      end else if (sat_clr) begin
         sat <= 1'b0;
      end else if (sat_event) begin
         sat <= 1'b1;
      end
   end
`else
   logic [DW-1:0] prod;

   // Truncating product and wrapping sum.
   always_comb begin
      prod     = a * b;
      next_acc = acc + prod;
   end
`endif

   // Accumulator register; a clear takes priority so that a WRITE cycle
   // leaves the next dot product starting from zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= next_acc;
      end
   end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// ---------------------------------------------------------------------------
// matmul_seq_ctrl
//
// Sequencer for C = A x B on N x N unsigned matrices stored row-major in
// single-ported memories with combinational read. For every C element it
// runs N MAC cycles (one product per cycle) followed by a single WRITE cycle,
// then pulses done for one cycle after the last element.
//
// Parameters:
//    N   matrix dimension, legal 2..10
//    DW  data word width
//    AW  memory address width
//
// Ports:
//    clk     in   system clock, rising edge
//    rst     in   asynchronous active-low reset
//    start   in   one-cycle run request, only looked at in IDLE
//    a_addr  out  address into memory A (i*N+k)
//    a_data  in   read data from memory A
//    b_addr  out  address into memory B (k*N+j)
//    b_data  in   read data from memory B
//    c_addr  out  address into memory C (i*N+j)
//    c_data  out  write data for memory C (the accumulator)
//    c_we    out  write enable for memory C, high only in WRITE
//    busy    out  high while MAC/WRITE cycles run
//    done    out  one-cycle completion pulse
//    sat     out  (MATMUL_SAT_EN only) sticky saturation flag
//
// Optional feature macro: MATMUL_SAT_EN (saturating arithmetic + sat port).
// ---------------------------------------------------------------------------
module matmul_seq_ctrl
   import matmul_pkg::*;
#(
   parameter int N  = 4,
   parameter int DW = DEF_DW,
   parameter int AW = DEF_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_data,
   output logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_data,
   output logic [AW-1:0] c_addr,
   output logic [DW-1:0] c_data,
   output logic          c_we,
   output logic          busy,
   output logic          done
`ifdef MATMUL_SAT_EN
   ,
   output logic          sat
`endif
);

   // Address-width copies of N and N-1 keep the decode arithmetic in AW bits.
   localparam logic [AW-1:0] DIM  = AW'(N);
   localparam logic [AW-1:0] LAST = AW'(N - 1);

   state_t        state;
   state_t        next_state;
   logic [AW-1:0] i;
   logic [AW-1:0] j;
   logic [AW-1:0] k;
   logic [DW-1:0] acc;
   logic          acc_clr;
   logic          mac_en;
   logic          start_accept;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and control decode. The accumulator is cleared both when a
   // run starts and during each WRITE, so every dot product begins at zero.
   always_comb begin
      next_state   = state;
      acc_clr      = 1'b0;
      mac_en       = 1'b0;
      start_accept = 1'b0;
      c_we         = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               start_accept = 1'b1;
               acc_clr      = 1'b1;
               next_state   = MAC;
            end
         end
         MAC: begin
            busy   = 1'b1;
            mac_en = 1'b1;
            if (k == LAST) begin
               next_state = WRITE;
            end
         end
         WRITE: begin
            busy    = 1'b1;
            c_we    = 1'b1;
            acc_clr = 1'b1;
            if ((j == LAST) && (i == LAST)) begin
               next_state = DONE;
            end else begin
               next_state = MAC;
            end
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Loop counters: k walks the dot product, j the column, i the row.
   // They are zeroed on an accepted start and again when the run finishes so
   // the address outputs rest at zero between runs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         i <= '0;
         j <= '0;
         k <= '0;
      end else if (start_accept || (state == DONE)) begin
         i <= '0;
         j <= '0;
         k <= '0;
      end else begin
         case (state)
            MAC: begin
               if (k != LAST) begin
                  k <= k + 1'b1;
               end
            end
            WRITE: begin
               k <= '0;
               if (j != LAST) begin
                  j <= j + 1'b1;
               end else begin
                  j <= '0;
                  if (i != LAST) begin
                     i <= i + 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Row-major address decode, valid every cycle.
   always_comb begin
      a_addr = i * DIM + k;
      b_addr = k * DIM + j;
      c_addr = i * DIM + j;
      c_data = acc;
   end

   mac_unit #(
      .DW (DW)
   ) u_mac (
      .clk     (clk),
      .rst     (rst),
      .clr     (acc_clr),
      .en      (mac_en),
      .a       (a_data),
      .b       (b_data),
`ifdef MATMUL_SAT_EN
      .sat_clr (start_accept),
      .sat     (sat),
`endif
      .acc     (acc)
   );

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_matmul_seq_ctrl
//
// Self-checking bench for matmul_seq_ctrl (N=4). Operand memories live in the
// bench; expected C values come from a plain nested-loop matrix product.
// Build with MATMUL_SAT_EN defined to exercise the saturating variant.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_matmul_seq_ctrl;

   localparam int N       = 4;
   localparam int DW      = 32;
   localparam int AW      = 7;
   localparam int NN      = N * N;
   localparam int RUN_CYC = N * N * (N + 1) + 1;
   localparam logic [63:0] WORD_MAX = 64'h0000_0000_FFFF_FFFF;

   logic          clk   = 1'b0;
   logic          rst   = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] a_addr;
   logic [AW-1:0] b_addr;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] a_data;
   logic [DW-1:0] b_data;
   logic [DW-1:0] c_data;
   logic          c_we;
   logic          busy;
   logic          done;
`ifdef MATMUL_SAT_EN
   logic          sat;
`endif

   logic [DW-1:0] mem_a [0:127];
   logic [DW-1:0] mem_b [0:127];

   int            n_cmp  = 0;
   int            n_fail = 0;
   int            wr_addr_q [$];
   logic [DW-1:0] wr_data_q [$];
   int            done_cnt = 0;

   logic [DW-1:0] exp_c [0:NN-1];
   logic          exp_sat;
   logic          exp_sat_first;

   assign a_data = mem_a[a_addr];
   assign b_data = mem_b[b_addr];

   always #5 clk = ~clk;

   matmul_seq_ctrl #(
      .N  (N),
      .DW (DW),
      .AW (AW)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a_addr (a_addr),
      .a_data (a_data),
      .b_addr (b_addr),
      .b_data (b_data),
      .c_addr (c_addr),
      .c_data (c_data),
      .c_we   (c_we),
      .busy   (busy),
      .done   (done)
`ifdef MATMUL_SAT_EN
      ,
      .sat    (sat)
`endif
   );

   // Result-memory writes and done pulses are captured mid-cycle.
   always @(negedge clk) begin
      if (c_we) begin
         wr_addr_q.push_back(int'(c_addr));
         wr_data_q.push_back(c_data);
      end
      if (done) begin
         done_cnt = done_cnt + 1;
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp = n_cmp + 1;
      assert (obs === exp) else begin
         n_fail = n_fail + 1;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: C[i][j] = sum_k A[i][k]*B[k][j], wrapping or clamping.
   task automatic computeModel();
      exp_sat       = 1'b0;
      exp_sat_first = 1'b0;
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            logic [63:0] sum;
            sum = 64'd0;
            for (int t = 0; t < N; t++) begin
               logic [63:0] p;
               p = 64'(mem_a[r * N + t]) * 64'(mem_b[t * N + c]);
`ifdef MATMUL_SAT_EN
               if (p > WORD_MAX) begin
                  p       = WORD_MAX;
                  exp_sat = 1'b1;
                  if (r == 0 && c == 0 && t == 0) exp_sat_first = 1'b1;
               end
               sum = sum + p;
               if (sum > WORD_MAX) begin
                  sum     = WORD_MAX;
                  exp_sat = 1'b1;
               end
`else
               sum = (sum + p) & WORD_MAX;
`endif
            end
            exp_c[r * N + c] = sum[31:0];
         end
      end
   endtask

   // One run: start pulse, optional extra start pulses at cycles 10/40,
   // optional reset abort at abort_cyc (0 = none).
   task automatic applyStimulus(input string tag, input bit repulse, input int abort_cyc);
      int cyc;
      int wr_before;
      computeModel();
      wr_addr_q.delete();
      wr_data_q.delete();
      done_cnt = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput({tag, ".busy_c1"}, 64'(busy), 64'd1);
      cyc = 0;
      while (!done && cyc < RUN_CYC + 20) begin
         start = repulse && ((cyc + 1 == 10) || (cyc + 1 == 40));
         if (abort_cyc != 0 && cyc + 1 == abort_cyc) begin
            rst = 1'b0;
            #1;
            checkOutput({tag, ".abort_we"},   64'(c_we), 64'd0);
            checkOutput({tag, ".abort_busy"}, 64'(busy), 64'd0);
            checkOutput({tag, ".abort_done"}, 64'(done), 64'd0);
            checkOutput({tag, ".abort_wrs"}, 64'(wr_addr_q.size()), 64'((abort_cyc - 1) / (N + 1)));
            wr_before = wr_addr_q.size();
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b1;
            repeat (10) @(posedge clk);
            #1;
            checkOutput({tag, ".post_abort_wrs"},  64'(wr_addr_q.size()), 64'(wr_before));
            checkOutput({tag, ".post_abort_busy"}, 64'(busy), 64'd0);
            checkOutput({tag, ".post_abort_done"}, 64'(done_cnt), 64'd0);
            return;
         end
         @(posedge clk);
         #1;
         cyc = cyc + 1;
`ifdef MATMUL_SAT_EN
         if (cyc == 1) checkOutput({tag, ".sat_first_mac"}, 64'(sat), 64'(exp_sat_first));
`endif
      end
      start = 1'b0;
      checkOutput({tag, ".done_cycle"}, 64'(cyc + 1), 64'(RUN_CYC));
      checkOutput({tag, ".done_hi"},    64'(done), 64'd1);
      checkOutput({tag, ".busy_at_done"}, 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      checkOutput({tag, ".done_after"}, 64'(done), 64'd0);
      checkOutput({tag, ".busy_after"}, 64'(busy), 64'd0);
      checkOutput({tag, ".n_writes"},   64'(wr_addr_q.size()), 64'(NN));
      checkOutput({tag, ".done_pulses"}, 64'(done_cnt), 64'd1);
      for (int idx = 0; idx < NN && idx < wr_addr_q.size(); idx++) begin
         checkOutput($sformatf("%s.c_addr[%0d]", tag, idx), 64'(wr_addr_q[idx]), 64'(idx));
         checkOutput($sformatf("%s.c_data[%0d]", tag, idx), 64'(wr_data_q[idx]), 64'(exp_c[idx]));
      end
`ifdef MATMUL_SAT_EN
      checkOutput({tag, ".sat_end"}, 64'(sat), 64'(exp_sat));
`endif
   endtask

   task automatic fillConst(input logic [DW-1:0] va, input logic [DW-1:0] vb);
      for (int x = 0; x < 128; x++) begin
         mem_a[x] = va;
         mem_b[x] = vb;
      end
   endtask

   task automatic fillRandom();
      for (int x = 0; x < 128; x++) begin
         mem_a[x] = $urandom();
         mem_b[x] = $urandom();
      end
   endtask

   initial begin
      fillConst(32'd1, 32'd1);
      #3;
      rst = 1'b0;
      #20;
      $display("[TB] checking reset state");
      checkOutput("rst.a_addr", 64'(a_addr), 64'd0);
      checkOutput("rst.b_addr", 64'(b_addr), 64'd0);
      checkOutput("rst.c_addr", 64'(c_addr), 64'd0);
      checkOutput("rst.c_data", 64'(c_data), 64'd0);
      checkOutput("rst.c_we",   64'(c_we),   64'd0);
      checkOutput("rst.busy",   64'(busy),   64'd0);
      checkOutput("rst.done",   64'(done),   64'd0);
`ifdef MATMUL_SAT_EN
      checkOutput("rst.sat",    64'(sat),    64'd0);
`endif
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("idle.busy", 64'(busy), 64'd0);

      $display("[TB] all-ones operands");
      applyStimulus("ones", 1'b0, 0);

      $display("[TB] ramp A, identity B");
      for (int x = 0; x < 128; x++) begin
         mem_a[x] = 32'(x + 1);
         mem_b[x] = 32'd0;
      end
      for (int d = 0; d < N; d++) mem_b[d * N + d] = 32'd1;
      applyStimulus("ident", 1'b0, 0);

      $display("[TB] random operands");
      fillRandom();
      applyStimulus("rand0", 1'b0, 0);
      for (int x = 0; x < 128; x++) begin
         mem_a[x] = $urandom_range(0, 65535);
         mem_b[x] = $urandom_range(0, 65535);
      end
      applyStimulus("rand_small", 1'b0, 0);

      $display("[TB] start re-pulsed during a run");
      fillRandom();
      applyStimulus("repulse", 1'b1, 0);

      $display("[TB] reset abort at cycle 30, then full run");
      fillRandom();
      applyStimulus("abort", 1'b0, 30);
      applyStimulus("after_abort", 1'b0, 0);

      $display("[TB] 0x00010000 operands");
      fillConst(32'h0001_0000, 32'h0001_0000);
      applyStimulus("big", 1'b0, 0);

      $display("[TB] all-ones again after overflow run");
      fillConst(32'd1, 32'd1);
      applyStimulus("ones2", 1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
